// File: rtl/uart_resp_pkg.sv
// Shared FSM state type, protocol byte values and helpers for uart_reg_responder.
package uart_resp_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GET_ADDR,
        GET_DATA,
        EXEC,
        SEND
    } state_t;

    localparam logic [7:0] CMD_WRITE = 8'h57;
    localparam logic [7:0] CMD_READ  = 8'h52;
    localparam logic [7:0] RSP_ACK   = 8'h4B;
    localparam logic [7:0] RSP_ERR   = 8'h3F;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/uart_resp_timeout.sv
// Idle-cycle counter for a partially received frame; expired pulses on the
// TIMEOUT_CYCLES-th consecutive enabled cycle since the last clear.
module uart_resp_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] cnt_q;

    assign expired = enable && (cnt_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            cnt_q <= '0;
        end else if (enable && !expired) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/uart_reg_responder.sv
// Register-file responder on the uart RX/TX FIFO ports ('W' A D / 'R' A protocol).
// Optional partial-frame timeout enabled by defining UART_RESP_TIMEOUT_EN.
module uart_reg_responder
    import uart_resp_pkg::*;
#(
    parameter int unsigned NREGS          = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
    localparam int unsigned AW            = $clog2(NREGS)
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               rx_empty,
    input  logic [7:0]         r_data,
    output logic               rd_uart,
    input  logic               tx_full,
    output logic [7:0]         w_data,
    output logic               wr_uart,
    output logic [NREGS*8-1:0] regs_flat,
    output logic               reg_we,
    output logic [AW-1:0]      reg_addr,
    output logic [7:0]         err_cnt
);

    if (NREGS < 2 || NREGS > 256 || (NREGS & (NREGS - 1)) != 0 || TIMEOUT_CYCLES == 0)
    begin : g_bad_params
        $error("uart_reg_responder: illegal NREGS or TIMEOUT_CYCLES");
    end

    state_t                  state;
    logic [7:0]              cmd_q;
    logic [7:0]              addr_q;
    logic [7:0]              data_q;
    logic [NREGS-1:0][7:0]   regs_q;
    logic                    in_frame;
    logic                    addr_ok;
    logic [AW-1:0]           addr_idx;
    logic                    timeout_hit;

    assign in_frame  = (state == GET_ADDR) || (state == GET_DATA);
    assign addr_ok   = ({24'd0, addr_q} < NREGS);
    assign addr_idx  = addr_q[AW-1:0];
    assign regs_flat = regs_q;

    // FIFO strobes decode straight from state so the pop lands in the cycle r_data is latched.
    assign rd_uart = reset_n && !rx_empty && ((state == IDLE) || in_frame);
    assign wr_uart = reset_n && !tx_full && (state == SEND);

`ifdef UART_RESP_TIMEOUT_EN
    uart_resp_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (clk),
        .reset_n(reset_n),
        .clear  (!in_frame || rd_uart),
        .enable (in_frame && rx_empty),
        .expired(timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            cmd_q    <= 8'h00;
            addr_q   <= 8'h00;
            data_q   <= 8'h00;
            regs_q   <= '0;
            w_data   <= 8'h00;
            reg_we   <= 1'b0;
            reg_addr <= '0;
            err_cnt  <= 8'h00;
        end else begin
            reg_we <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (rd_uart) begin
                        cmd_q <= r_data;
                        state <= (r_data == CMD_WRITE || r_data == CMD_READ) ? GET_ADDR : EXEC;
                    end
                end
                GET_ADDR: begin
                    if (rd_uart) begin
                        addr_q <= r_data;
                        state  <= (cmd_q == CMD_WRITE) ? GET_DATA : EXEC;
                    end else if (timeout_hit) begin
                        state   <= IDLE;
                        err_cnt <= sat_inc8(err_cnt);
                    end
                end
                GET_DATA: begin
                    if (rd_uart) begin
                        data_q <= r_data;
                        state  <= EXEC;
                    end else if (timeout_hit) begin
                        state   <= IDLE;
                        err_cnt <= sat_inc8(err_cnt);
                    end
                end
                EXEC: begin
                    state <= SEND;
                    if (cmd_q == CMD_WRITE && addr_ok) begin
                        regs_q[addr_idx] <= data_q;
                        reg_we           <= 1'b1;
                        reg_addr         <= addr_idx;
                        w_data           <= RSP_ACK;
                    end else if (cmd_q == CMD_READ && addr_ok) begin
                        w_data <= regs_q[addr_idx];
                    end else begin
                        w_data  <= RSP_ERR;
                        err_cnt <= sat_inc8(err_cnt);
                    end
                end
                SEND: begin
                    if (wr_uart) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
